// File: rtl/retire_checker.sv
// retire_checker: watches per-core writeback ports and keeps a shadow register
// file for each core. A start/done handshake runs until every core has halted
// or the cycle limit is reached, then checks one selected register.
// Optional trace output: define RETIRE_TRACE_EN.
module retire_checker #(
  parameter int unsigned NUM_CORES      = 1,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CORE_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CORE_W-1:0]         chk_core,
  input  logic [4:0]                chk_reg,
  input  logic [XLEN-1:0]           chk_val,
  input  logic [NUM_CORES-1:0]      wb_valid,
  input  logic [5*NUM_CORES-1:0]    wb_rd,
  input  logic [XLEN*NUM_CORES-1:0] wb_data,
  input  logic [NUM_CORES-1:0]      halt,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [31:0]               retire_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nx;
  logic [NUM_CORES-1:0]  halt_mask, mask_nx;
  logic [31:0]           cyc_cnt;
  logic [CORE_W-1:0]     core_q;
  logic [4:0]            reg_q;
  logic [XLEN-1:0]       val_q;
  logic [XLEN-1:0]       shadow [NUM_CORES][32];
  logic                  all_halted;
  logic                  hit_limit;
  logic                  accept;
  logic [31:0]           wb_count;
  logic [32:0]           cnt_sum;
  logic [XLEN-1:0]       sel_val;
  logic                  pass_nx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: halts arriving this cycle count toward completion, and a
  // complete halt mask takes priority over the cycle limit
  always_comb begin
    mask_nx    = halt_mask | halt;
    all_halted = &mask_nx;
    hit_limit  = (cyc_cnt == LIMIT);
    accept     = start && ((state == S_IDLE) || (state == S_DONE));
    state_nx   = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RUN;
      S_RUN: begin
        if (all_halted)     state_nx = S_CHECK;
        else if (hit_limit) state_nx = S_DONE;
      end
      S_CHECK: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Retire popcount and saturating sum
  always_comb begin
    wb_count = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      wb_count = wb_count + 32'(wb_valid[i]);
    cnt_sum = {1'b0, retire_cnt} + {1'b0, wb_count};
  end

  // Selected shadow register and comparison result
  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      if (core_q == CORE_W'(i)) sel_val = shadow[i][reg_q];
    if (reg_q == 5'd0) sel_val = '0;
    pass_nx = (32'(core_q) < NUM_CORES) && (sel_val == val_q);
  end

  // Datapath: latches, shadow files, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_mask  <= '0;
      cyc_cnt    <= '0;
      core_q     <= '0;
      reg_q      <= '0;
      val_q      <= '0;
      retire_cnt <= '0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++)
        for (int unsigned r = 0; r < 32; r++)
          shadow[i][r] <= '0;
    end else begin
      busy <= (state_nx == S_RUN) || (state_nx == S_CHECK);
      done <= (state_nx == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            core_q     <= chk_core;
            reg_q      <= chk_reg;
            val_q      <= chk_val;
            halt_mask  <= '0;
            cyc_cnt    <= '0;
            retire_cnt <= '0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++)
              for (int unsigned r = 0; r < 32; r++)
                shadow[i][r] <= '0;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NUM_CORES; i++)
            if (wb_valid[i] && (wb_rd[5*i +: 5] != 5'd0))
              shadow[i][wb_rd[5*i +: 5]] <= wb_data[XLEN*i +: XLEN];
          retire_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
          halt_mask  <= mask_nx;
          cyc_cnt    <= cyc_cnt + 32'd1;
          if (!all_halted && hit_limit) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        S_CHECK: pass <= pass_nx;
        default: ;
      endcase
    end
  end

`ifdef RETIRE_TRACE_EN
  // Simulation trace of accepted writebacks and the final result
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_RUN))
      for (int unsigned i = 0; i < NUM_CORES; i++)
        if (wb_valid[i])
          $display("%0t retire core %0d rd %0d data %0h", $time, i,
                   wb_rd[5*i +: 5], wb_data[XLEN*i +: XLEN]);
    if (rst_n && (state != S_DONE) && (state_nx == S_DONE)) begin
      if (state == S_RUN) $display("%0t retire_checker TIMEOUT", $time);
      else if (pass_nx)   $display("%0t retire_checker PASS", $time);
      else                $display("%0t retire_checker FAIL", $time);
    end
  end
`endif

endmodule

// File: tb/tb_retire_checker.sv
module tb_retire_checker;

  localparam int unsigned T1 = 16;
  localparam int unsigned T2 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // single-core instance
  logic        s1_start;
  logic [0:0]  s1_core;
  logic [4:0]  s1_reg;
  logic [31:0] s1_val;
  logic [0:0]  s1_wbv;
  logic [4:0]  s1_rd;
  logic [31:0] s1_data;
  logic [0:0]  s1_halt;
  logic        o1_busy, o1_done, o1_pass, o1_to;
  logic [31:0] o1_cnt;

  // dual-core instance
  logic        s2_start;
  logic [0:0]  s2_core;
  logic [4:0]  s2_reg;
  logic [31:0] s2_val;
  logic [1:0]  s2_wbv;
  logic [9:0]  s2_rd;
  logic [63:0] s2_data;
  logic [1:0]  s2_halt;
  logic        o2_busy, o2_done, o2_pass, o2_to;
  logic [31:0] o2_cnt;

  retire_checker #(.NUM_CORES(1), .XLEN(32), .TIMEOUT_CYCLES(T1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .chk_core(s1_core),
    .chk_reg(s1_reg), .chk_val(s1_val), .wb_valid(s1_wbv), .wb_rd(s1_rd),
    .wb_data(s1_data), .halt(s1_halt), .busy(o1_busy), .done(o1_done),
    .pass(o1_pass), .timeout(o1_to), .retire_cnt(o1_cnt));

  retire_checker #(.NUM_CORES(2), .XLEN(32), .TIMEOUT_CYCLES(T2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .chk_core(s2_core),
    .chk_reg(s2_reg), .chk_val(s2_val), .wb_valid(s2_wbv), .wb_rd(s2_rd),
    .wb_data(s2_data), .halt(s2_halt), .busy(o2_busy), .done(o2_done),
    .pass(o2_pass), .timeout(o2_to), .retire_cnt(o2_cnt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic u1_start(input logic c, input logic [4:0] r, input logic [31:0] v);
    s1_start = 1'b1; s1_core = c; s1_reg = r; s1_val = v;
    cyc();
    s1_start = 1'b0;
  endtask

  task automatic u1_wb(input logic [4:0] r, input logic [31:0] d);
    s1_wbv = 1'b1; s1_rd = r; s1_data = d;
    cyc();
    s1_wbv = 1'b0;
  endtask

  task automatic u1_halt();
    s1_halt = 1'b1;
    cyc();
    s1_halt = 1'b0;
  endtask

  typedef struct {
    logic        core;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  creg;
    logic [31:0] cval;
    logic        exp_pass;
  } vec_t;

  vec_t vt [7];

  // reference model state for random runs
  logic [31:0] m_sh [2][32];

  initial begin
    vt[0] = '{1'b0, 5'd3,  32'd30,         5'd3,  32'd30,         1'b1};
    vt[1] = '{1'b0, 5'd3,  32'd31,         5'd3,  32'd30,         1'b0};
    vt[2] = '{1'b0, 5'd0,  32'h55,         5'd0,  32'd0,          1'b1};
    vt[3] = '{1'b0, 5'd0,  32'h55,         5'd0,  32'h55,         1'b0};
    vt[4] = '{1'b0, 5'd31, 32'hFFFF_FFFF,  5'd31, 32'hFFFF_FFFF,  1'b1};
    vt[5] = '{1'b0, 5'd5,  32'd7,          5'd6,  32'd0,          1'b1};
    vt[6] = '{1'b1, 5'd3,  32'd0,          5'd3,  32'd0,          1'b0};

    s1_start = 0; s1_core = 0; s1_reg = 0; s1_val = 0; s1_wbv = 0; s1_rd = 0;
    s1_data = 0; s1_halt = 0;
    s2_start = 0; s2_core = 0; s2_reg = 0; s2_val = 0; s2_wbv = 0; s2_rd = 0;
    s2_data = 0; s2_halt = 0;
    rst_n = 1'b0;
    cyc(); cyc();
    chk1("rst_busy1", o1_busy, 0); chk1("rst_done1", o1_done, 0);
    chk1("rst_pass1", o1_pass, 0); chk1("rst_to1", o1_to, 0);
    chk("rst_cnt1", o1_cnt, 0);
    chk1("rst_busy2", o2_busy, 0); chk("rst_cnt2", o2_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // basic pass run
    u1_start(0, 5'd3, 32'd30);
    chk1("a_busy", o1_busy, 1); chk1("a_done0", o1_done, 0);
    u1_wb(5'd1, 32'd10); u1_wb(5'd2, 32'd20); u1_wb(5'd3, 32'd30);
    u1_halt();
    chk1("a_check_busy", o1_busy, 1); chk1("a_check_done", o1_done, 0);
    cyc();
    chk1("a_done", o1_done, 1); chk1("a_busy_off", o1_busy, 0);
    chk1("a_pass", o1_pass, 1); chk1("a_to", o1_to, 0);
    chk("a_cnt", o1_cnt, 3);

    // failing run, then restart without reset
    u1_start(0, 5'd3, 32'd30);
    chk("b_cnt_clr", o1_cnt, 0); chk1("b_pass_clr", o1_pass, 0);
    chk1("b_done_clr", o1_done, 0);
    u1_wb(5'd1, 32'd10); u1_wb(5'd2, 32'd20); u1_wb(5'd3, 32'd31);
    u1_halt(); cyc();
    chk1("b_done", o1_done, 1); chk1("b_pass", o1_pass, 0);
    chk("b_cnt", o1_cnt, 3);
    u1_start(0, 5'd3, 32'd30);
    chk("b2_cnt_clr", o1_cnt, 0);
    u1_wb(5'd3, 32'd30);
    u1_halt(); cyc();
    chk1("b2_done", o1_done, 1); chk1("b2_pass", o1_pass, 1);
    chk("b2_cnt", o1_cnt, 1);

    // single-writeback table
    for (int i = 0; i < 7; i++) begin
      u1_start(vt[i].core, vt[i].creg, vt[i].cval);
      u1_wb(vt[i].rd, vt[i].data);
      u1_halt(); cyc();
      chk1($sformatf("t%0d_done", i), o1_done, 1);
      chk1($sformatf("t%0d_pass", i), o1_pass, vt[i].exp_pass);
      chk1($sformatf("t%0d_to", i), o1_to, 0);
      chk($sformatf("t%0d_cnt", i), o1_cnt, 1);
    end

    // timeout without halt
    begin
      int n = 0;
      u1_start(0, 5'd0, 32'd0);
      while (!o1_done && n < 100) begin cyc(); n++; end
      chk("to_latency", n, T1);
      chk1("to_flag", o1_to, 1); chk1("to_pass", o1_pass, 0);
      chk1("to_busy", o1_busy, 0);
    end

    // halt in the final RUN cycle beats the timeout
    u1_start(0, 5'd0, 32'd0);
    repeat (T1 - 1) cyc();
    u1_halt();
    chk1("hl_done0", o1_done, 0); chk1("hl_busy", o1_busy, 1);
    cyc();
    chk1("hl_done", o1_done, 1); chk1("hl_to", o1_to, 0);
    chk1("hl_pass", o1_pass, 1);

    // start during RUN is ignored
    u1_start(0, 5'd0, 32'd0);
    u1_wb(5'd0, 32'h55);
    s1_start = 1'b1; s1_reg = 5'd3; s1_val = 32'd99;
    cyc();
    s1_start = 1'b0;
    chk("ig_cnt", o1_cnt, 1); chk1("ig_busy", o1_busy, 1);
    u1_halt(); cyc();
    chk1("ig_done", o1_done, 1); chk1("ig_pass", o1_pass, 1);
    chk("ig_cnt2", o1_cnt, 1);

    // dual core: simultaneous writes, staggered halts
    s2_start = 1'b1; s2_core = 1'b1; s2_reg = 5'd5; s2_val = 32'hB;
    cyc();
    s2_start = 1'b0;
    s2_wbv = 2'b11; s2_rd = {5'd5, 5'd5}; s2_data = {32'hB, 32'hA};
    cyc();
    s2_wbv = 2'b00;
    s2_halt = 2'b01; cyc(); s2_halt = 2'b00;
    repeat (4) cyc();
    chk1("d_wait_busy", o2_busy, 1); chk1("d_wait_done", o2_done, 0);
    s2_halt = 2'b10; cyc(); s2_halt = 2'b00;
    chk1("d_check_done", o2_done, 0);
    cyc();
    chk1("d_done", o2_done, 1); chk1("d_pass", o2_pass, 1);
    chk1("d_to", o2_to, 0); chk("d_cnt", o2_cnt, 2);

    // reset in the middle of a run
    u1_start(0, 5'd3, 32'd30);
    u1_wb(5'd3, 32'd30);
    rst_n = 1'b0;
    cyc();
    chk1("r_busy", o1_busy, 0); chk1("r_done", o1_done, 0);
    chk1("r_pass", o1_pass, 0); chk1("r_to", o1_to, 0);
    chk("r_cnt", o1_cnt, 0);
    rst_n = 1'b1;
    cyc();
    chk1("r_idle", o1_busy, 0);

    // randomized dual-core runs against the reference model
    for (int run = 0; run < 60; run++) begin
      logic        c;
      logic [4:0]  r;
      logic [31:0] v, expv;
      logic [1:0]  mask;
      int          ncyc, retired;
      bit          halted_all;
      c = 1'($urandom_range(0, 1));
      r = 5'($urandom_range(0, 4));
      v = (run % 5 == 0) ? $urandom : 32'($urandom_range(0, 3));
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 32; b++) m_sh[a][b] = '0;
      mask = '0; ncyc = 0; retired = 0; halted_all = 0;
      s2_start = 1'b1; s2_core = c; s2_reg = r; s2_val = v;
      cyc();
      s2_start = 1'b0;
      while (!halted_all && ncyc < int'(T2)) begin
        for (int i = 0; i < 2; i++) begin
          s2_wbv[i]        = ($urandom_range(0, 1) == 1);
          s2_rd[5*i +: 5]  = 5'($urandom_range(0, 4));
          s2_data[32*i +: 32] = 32'($urandom_range(0, 3));
          s2_halt[i]       = ($urandom_range(0, 15) == 0);
          if (s2_wbv[i]) begin
            retired++;
            if (s2_rd[5*i +: 5] != 0) m_sh[i][s2_rd[5*i +: 5]] = s2_data[32*i +: 32];
          end
        end
        mask = mask | s2_halt;
        ncyc++;
        halted_all = (mask == 2'b11);
        cyc();
      end
      // garbage while checking / done must be ignored
      s2_wbv = 2'($urandom); s2_rd = 10'($urandom); s2_data = {$urandom, $urandom};
      s2_halt = 2'($urandom);
      if (halted_all) begin
        chk1($sformatf("rnd%0d_chk_done", run), o2_done, 0);
        cyc();
      end
      s2_wbv = '0; s2_halt = '0;
      expv = (r == 0) ? 32'd0 : m_sh[c][r];
      chk1($sformatf("rnd%0d_done", run), o2_done, 1);
      chk1($sformatf("rnd%0d_to", run), o2_to, !halted_all);
      chk1($sformatf("rnd%0d_pass", run), o2_pass, halted_all && (expv == v));
      chk($sformatf("rnd%0d_cnt", run), o2_cnt, retired);
      cyc();
      chk1($sformatf("rnd%0d_hold", run), o2_done, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
